// File: rtl/delay_addr_pkg.sv
// Shared types and helpers for the delay-line address generator.
package delay_addr_pkg;

  localparam int unsigned CALC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Limit a requested tap delay to the deepest sample the buffer still holds.
  function automatic logic [CALC_W-1:0] clamp_delay(input logic [CALC_W-1:0] d,
                                                    input logic [CALC_W-1:0] depth);
    return (d >= depth) ? depth - CALC_W'(1) : d;
  endfunction

endpackage

// File: rtl/delay_addr_modsub.sv
// Read address for one tap: (write address - clamped delay) mod DEPTH.
module delay_addr_modsub
  import delay_addr_pkg::*;
#(
  parameter int unsigned DEPTH = 66,
  parameter int unsigned AW    = 7
) (
  input  logic [AW-1:0] addr_w_i,
  input  logic [AW-1:0] delay_i,
  output logic [AW-1:0] rd_addr_c_o,
  output logic          clamped_c_o
);

  localparam int unsigned SW = AW + 1;

  logic [AW-1:0] d_k;
  logic [SW-1:0] diff;

  // One extra bit catches the borrow; a negative difference wraps by DEPTH.
  always_comb begin
    clamped_c_o = (CALC_W'(delay_i) >= CALC_W'(DEPTH));
    d_k         = AW'(clamp_delay(CALC_W'(delay_i), CALC_W'(DEPTH)));
    diff        = {1'b0, addr_w_i} - {1'b0, d_k};
    if (diff[AW]) begin
      diff = diff + SW'(DEPTH);
    end
    rd_addr_c_o = diff[AW-1:0];
  end

endmodule

// File: rtl/delay_addr_gen.sv
// Write/read address sequencer for a circular sample buffer held in external dual-port RAM:
// one write per enable edge, then NTAP delayed reads.
module delay_addr_gen
  import delay_addr_pkg::*;
#(
  parameter int unsigned DEPTH = 66,
  parameter int unsigned AW    = 7,
  parameter int unsigned NTAP  = 4,
  parameter int unsigned TW    = (NTAP > 1) ? $clog2(NTAP) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NTAP*AW-1:0] delay,
  output logic               wren,
  output logic [AW-1:0]      address_w,
  output logic               rden,
  output logic [AW-1:0]      address_r,
  output logic [TW-1:0]      tap_idx,
  output logic               busy,
  output logic               done,
  output logic               delay_err,
  output logic               overrun
);

  state_e        state_q, state_d;
  logic          enable_q;
  logic          armed_q;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] address_w_q, address_w_d;
  logic [AW-1:0] address_r_q, address_r_d;
  logic [TW-1:0] tap_q, tap_d;
  logic          wren_q, wren_d;
  logic          rden_q, rden_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          delay_err_q, delay_err_d;
  logic          overrun_q, overrun_d;

  logic          edge_c;
  logic [TW-1:0] rd_tap_c;
  logic [AW-1:0] sel_delay_c;
  logic [AW-1:0] rd_addr_c;
  logic          clamped_c;

  // armed_q blocks a false edge when enable is already high as reset releases.
  assign edge_c   = enable & ~enable_q & armed_q;
  assign rd_tap_c = (state_q == ST_WR) ? '0 : tap_q + 1'b1;

  always_comb begin
    sel_delay_c = delay[AW-1:0];
    for (int k = 0; k < int'(NTAP); k++) begin
      if (TW'(k) == rd_tap_c) begin
        sel_delay_c = delay[k*AW +: AW];
      end
    end
  end

  delay_addr_modsub #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_modsub (
    .addr_w_i    (address_w_q),
    .delay_i     (sel_delay_c),
    .rd_addr_c_o (rd_addr_c),
    .clamped_c_o (clamped_c)
  );

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    address_w_d = address_w_q;
    address_r_d = address_r_q;
    tap_d       = tap_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    delay_err_d = 1'b0;
    overrun_d   = edge_c & (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (edge_c) begin
          state_d     = ST_WR;
          wren_d      = 1'b1;
          busy_d      = 1'b1;
          address_w_d = wp_q;
          wp_d        = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
        end
      end
      ST_WR, ST_RD: begin
        if (state_q == ST_RD && tap_q == TW'(NTAP - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_RD;
          tap_d       = rd_tap_c;
          rden_d      = 1'b1;
          busy_d      = 1'b1;
          address_r_d = rd_addr_c;
          delay_err_d = clamped_c;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      armed_q     <= 1'b0;
      wp_q        <= '0;
      address_w_q <= '0;
      address_r_q <= '0;
      tap_q       <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      delay_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable;
      armed_q     <= armed_q | ~enable;
      wp_q        <= wp_d;
      address_w_q <= address_w_d;
      address_r_q <= address_r_d;
      tap_q       <= tap_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      delay_err_q <= delay_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign wren      = wren_q;
  assign address_w = address_w_q;
  assign rden      = rden_q;
  assign address_r = address_r_q;
  assign tap_idx   = tap_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign delay_err = delay_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_addr_gen.sv
// Directed self-checking bench: default instance plus a DEPTH=16/NTAP=1 instance.
module tb_delay_addr_gen;

  localparam int unsigned DEPTH = 66;
  localparam int unsigned AW    = 7;
  localparam int unsigned NTAP  = 4;
  localparam int unsigned TW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               enable;
  logic [NTAP*AW-1:0] delay;
  logic               wren, rden, busy, done, delay_err, overrun;
  logic [AW-1:0]      address_w, address_r;
  logic [TW-1:0]      tap_idx;

  logic               enable_b;
  logic [3:0]         delay_b;
  logic               wren_b, rden_b, busy_b, done_b, delay_err_b, overrun_b;
  logic [3:0]         address_w_b, address_r_b;
  logic [0:0]         tap_idx_b;

  delay_addr_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .delay     (delay),
    .wren      (wren),
    .address_w (address_w),
    .rden      (rden),
    .address_r (address_r),
    .tap_idx   (tap_idx),
    .busy      (busy),
    .done      (done),
    .delay_err (delay_err),
    .overrun   (overrun)
  );

  delay_addr_gen #(.DEPTH(16), .AW(4), .NTAP(1), .TW(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable_b),
    .delay     (delay_b),
    .wren      (wren_b),
    .address_w (address_w_b),
    .rden      (rden_b),
    .address_r (address_r_b),
    .tap_idx   (tap_idx_b),
    .busy      (busy_b),
    .done      (done_b),
    .delay_err (delay_err_b),
    .overrun   (overrun_b)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int ovr_cnt = 0;

  logic [AW-1:0] got_rd  [NTAP];
  logic          got_err [NTAP];

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_rd(input int aw, input int d);
    int dk;
    dk = (d >= int'(DEPTH)) ? int'(DEPTH) - 1 : d;
    return (aw - dk + int'(DEPTH)) % int'(DEPTH);
  endfunction

  // One full sample: write, NTAP reads, done pulse. Assumes idle with enable low.
  task automatic run_seq(input int exp_aw);
    enable = 1'b1;
    tick();
    check("wr_wren", 32'(wren), 32'd1);
    check("wr_addr", 32'(address_w), 32'(exp_aw));
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_rden", 32'(rden), 32'd0);
    enable = 1'b0;
    for (int k = 0; k < int'(NTAP); k++) begin
      int d;
      d = int'(delay[k*AW +: AW]);
      tick();
      check("rd_rden", 32'(rden), 32'd1);
      check("rd_wren", 32'(wren), 32'd0);
      check("rd_tap", 32'(tap_idx), 32'(k));
      check("rd_addr", 32'(address_r), 32'(exp_rd(exp_aw, d)));
      check("rd_err", 32'(delay_err), 32'(d >= int'(DEPTH)));
      check("rd_addrw_hold", 32'(address_w), 32'(exp_aw));
      got_rd[k]  = address_r;
      got_err[k] = delay_err;
    end
    tick();
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_rden", 32'(rden), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    enable_b = 1'b0;
    delay    = {7'd65, 7'd5, 7'd1, 7'd0};
    delay_b  = 4'd15;
    repeat (3) tick();
    check("rst_outs", 32'({wren, rden, busy, done, delay_err, overrun, address_w, address_r, tap_idx}), 32'd0);
    check("rst_outs_b", 32'({wren_b, rden_b, busy_b, done_b, delay_err_b, overrun_b, address_w_b, address_r_b, tap_idx_b}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 67 samples spaced 10 cycles: write address wraps 65 -> 0
    for (int i = 0; i < 67; i++) begin
      run_seq(i % int'(DEPTH));
      if (i == 0) begin
        check("r039_tap0", 32'(got_rd[0]), 32'd0);
        check("r039_tap1", 32'(got_rd[1]), 32'd65);
        check("r039_tap2", 32'(got_rd[2]), 32'd61);
        check("r039_tap3", 32'(got_rd[3]), 32'd1);
      end
      repeat (3) tick();
    end
    check("r040_no_overrun", 32'(ovr_cnt), 32'd0);

    // Clamped tap 2 at write address 10
    for (int i = 1; i < 10; i++) begin
      run_seq(i);
      tick();
    end
    delay[2*AW +: AW] = 7'd100;
    run_seq(10);
    check("r041_tap2_addr", 32'(got_rd[2]), 32'd11);
    check("r041_tap2_err", 32'(got_err[2]), 32'd1);
    check("r041_tap1_err", 32'(got_err[1]), 32'd0);
    check("r041_tap3_err", 32'(got_err[3]), 32'd0);
    delay[2*AW +: AW] = 7'd5;
    tick();

    // Second edge two cycles after the first is dropped
    enable = 1'b1;
    tick();
    check("r042_wr", 32'(address_w), 32'd11);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check("r042_ovr", 32'(overrun), 32'd1);
    check("r042_nowr", 32'(wren), 32'd0);
    enable = 1'b0;
    tick();
    check("r042_ovr_pulse", 32'(overrun), 32'd0);
    repeat (8) tick();
    check("r042_ovr_cnt", 32'(ovr_cnt), 32'd1);
    run_seq(12);
    tick();

    // Async reset during the tap-1 read, enable held high through release
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    tick();
    check("r043_tap1", 32'(tap_idx), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r043_async", 32'({wren, rden, busy, done, delay_err, overrun, address_w, address_r, tap_idx}), 32'd0);
    enable = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r035_no_edge", 32'({wren, busy}), 32'd0);
    end
    enable = 1'b0;
    tick();
    run_seq(0);
    tick();

    // DEPTH=16, NTAP=1, delay 15: read lands one ahead of the write
    for (int i = 0; i < 20; i++) begin
      enable_b = 1'b1;
      tick();
      check("b_wren", 32'(wren_b), 32'd1);
      check("b_wr_addr", 32'(address_w_b), 32'(i % 16));
      enable_b = 1'b0;
      tick();
      check("b_rden", 32'(rden_b), 32'd1);
      check("b_rd_addr", 32'(address_r_b), 32'((i % 16 + 1) % 16));
      check("b_rd_err", 32'(delay_err_b), 32'd0);
      tick();
      check("b_done", 32'(done_b), 32'd1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
